// File: rtl/alu_shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: ALU opcodes,
// shift-kind encodings and the controller state enum.
package alu_shift_sequencer_pkg;

    localparam logic [3:0] ALU_SLL1 = 4'b1010;
    localparam logic [3:0] ALU_SRL1 = 4'b1011;
    localparam logic [3:0] ALU_SLA1 = 4'b1100;
    localparam logic [3:0] ALU_SRA1 = 4'b1101;
    localparam logic [3:0] ALU_ZERO = 4'b1111;

    typedef enum logic [1:0] {
        SHIFT_LL = 2'b00,
        SHIFT_LR = 2'b01,
        SHIFT_AL = 2'b10,
        SHIFT_AR = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Single-bit ALU opcode that applies one step of the given shift kind.
    function automatic logic [3:0] shift_opcode(input shift_type_e kind);
        logic [3:0] op;
        op = ALU_ZERO;
        case (kind)
            SHIFT_LL: op = ALU_SLL1;
            SHIFT_LR: op = ALU_SRL1;
            SHIFT_AL: op = ALU_SLA1;
            SHIFT_AR: op = ALU_SRA1;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_shift_sequencer_if.sv
// Request/response and ALU-side signals of the shift sequencer. The slave
// modport is the sequencer; the master modport is the parent wiring the ALU.
interface alu_shift_sequencer_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);

    logic                   start;
    logic [1:0]             shift_type;
    logic [DATA_WIDTH-1:0]  operand;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  result;
    logic [DATA_WIDTH-1:0]  alu_in_1;
    logic [DATA_WIDTH-1:0]  alu_in_2;
    logic [3:0]             alu_op;
    logic [DATA_WIDTH-1:0]  alu_result;

    modport slave (
        input  start, shift_type, operand, shamt, alu_result,
        output busy, done, result, alu_in_1, alu_in_2, alu_op
    );

    modport master (
        output start, shift_type, operand, shamt, alu_result,
        input  busy, done, result, alu_in_1, alu_in_2, alu_op
    );

endinterface

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shifter built on a one-bit-per-operation ALU: the accumulator is
// fed through the ALU once per cycle until the requested amount is applied.
module alu_shift_sequencer
    import alu_shift_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_shift_sequencer_if.slave bus
);

    state_e                 r_state;
    state_e                 w_next_state;
    logic [DATA_WIDTH-1:0]  r_acc;
    logic [DATA_WIDTH-1:0]  w_acc_next;
    logic [SHAMT_WIDTH-1:0] r_cnt;
    logic [SHAMT_WIDTH-1:0] w_cnt_next;
    shift_type_e            r_type;
    shift_type_e            w_type_next;
    logic [DATA_WIDTH-1:0]  r_result;
    logic [3:0]             w_alu_op;

    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_type_next  = r_type;
        w_alu_op     = ALU_ZERO;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_acc_next   = bus.operand;
                    w_cnt_next   = bus.shamt;
                    w_type_next  = shift_type_e'(bus.shift_type);
                    w_next_state = (bus.shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                w_alu_op   = shift_opcode(r_type);
                w_acc_next = bus.alu_result;
                w_cnt_next = r_cnt - SHAMT_WIDTH'(1);
                if (r_cnt == SHAMT_WIDTH'(1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_type   <= SHIFT_LL;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_type  <= w_type_next;
            // Capture the value the accumulator takes on this edge, so the final
            // shift step (or the raw operand when shamt is 0) lands in result.
            if (w_next_state == ST_DONE) begin
                r_result <= w_acc_next;
            end
        end
    end

    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.result   = r_result;
    assign bus.alu_in_1 = r_acc;
    assign bus.alu_in_2 = '0;
    assign bus.alu_op   = w_alu_op;

endmodule
